// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the uart transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int unsigned TxReqNum      = 4;
  localparam int unsigned TxPrioWidth   = 3;
  localparam int unsigned TxDataWidth   = 8;
  localparam int unsigned UartWordWidth = 32;

  typedef logic [TxDataWidth-1:0] TxByteT;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tx_arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational winner selection: highest priority among valid requesters,
// ties resolved round-robin starting just after rr_ptr.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NumReq    = TxReqNum,
  parameter int unsigned PrioWidth = TxPrioWidth,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]           valid,
  input  logic [NumReq*PrioWidth-1:0] prio,
  input  logic [IdxWidth-1:0]         rr_ptr,
  output logic                        any,
  output logic [IdxWidth-1:0]         idx
);

  logic [PrioWidth-1:0] prio_a [NumReq];
  logic [PrioWidth-1:0] best;
  logic [PrioWidth-1:0] cur;
  logic [IdxWidth-1:0]  pos;

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign prio_a[g] = prio[g*PrioWidth +: PrioWidth];
  end

  // Scan in rotated order; a strictly greater priority is needed to displace,
  // so the first candidate after rr_ptr wins among equals.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    best = '0;
    cur  = '0;
    pos  = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      pos = IdxWidth'((32'(rr_ptr) + k) % NumReq);
      cur = prio_a[pos];
      if (valid[pos] && (!any || (cur > best))) begin
        any  = 1'b1;
        idx  = pos;
        best = cur;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among NumReq byte producers, one byte per grant.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NumReq    = TxReqNum,
  parameter int unsigned DataWidth = TxDataWidth,
  parameter int unsigned PrioWidth = TxPrioWidth,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NumReq-1:0]           req_valid,
  input  logic [NumReq*DataWidth-1:0] req_data,
  input  logic [NumReq*PrioWidth-1:0] req_prio,
  output logic [NumReq-1:0]           req_next,
  output logic [UartWordWidth-1:0]    uart_d_in,
  output logic                        uart_rts,
  input  logic                        uart_next,
  output logic [IdxWidth-1:0]         grant_id,
  output logic                        proto_err
);

  tx_arb_state_t        state_q, state_d;
  logic [IdxWidth-1:0]  grant_q, grant_d;
  logic [IdxWidth-1:0]  rr_q, rr_d;
  logic                 err_q, err_d;
  logic                 pick_any;
  logic [IdxWidth-1:0]  pick_idx;
  logic [DataWidth-1:0] data_a [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign data_a[g] = req_data[g*DataWidth +: DataWidth];
  end

  uart_tx_arbiter_rr_pick #(
    .NumReq    (NumReq),
    .PrioWidth (PrioWidth)
  ) u_pick (
    .valid  (req_valid),
    .prio   (req_prio),
    .rr_ptr (rr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IdxWidth'(NumReq - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  // Pop has priority over a simultaneous valid drop; reset suppresses the pop.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    err_d    = err_q;
    req_next = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (uart_next) begin
          req_next[grant_q] = !reset;
          rr_d              = grant_q;
          state_d           = IDLE;
        end else if (!req_valid[grant_q]) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign uart_rts  = (state_q == BUSY);
  assign uart_d_in = (state_q == BUSY) ? UartWordWidth'(data_a[grant_q]) : '0;
  assign grant_id  = grant_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [11:0] req_prio;
  logic [3:0]  req_next;
  logic [31:0] uart_d_in;
  logic        uart_rts;
  logic        uart_next;
  logic [1:0]  grant_id;
  logic        proto_err;

  logic [7:0]  data_a [4];
  logic [2:0]  prio_a [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = {data_a[3], data_a[2], data_a[1], data_a[0]};
    req_prio = {prio_a[3], prio_a[2], prio_a[1], prio_a[0]};
  end

  uart_tx_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_prio  (req_prio),
    .req_next  (req_next),
    .uart_d_in (uart_d_in),
    .uart_rts  (uart_rts),
    .uart_next (uart_next),
    .grant_id  (grant_id),
    .proto_err (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b0000;
    uart_next = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_prio(input int p0, input int p1, input int p2, input int p3);
    prio_a[0] = 3'(p0);
    prio_a[1] = 3'(p1);
    prio_a[2] = 3'(p2);
    prio_a[3] = 3'(p3);
  endtask

  // Waits for the next grant, returns its index (-1 on timeout).
  task automatic next_grant(output int id);
    id = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (uart_rts) begin
        id = int'(grant_id);
        tick();
        return;
      end
      tick();
    end
  endtask

  // Reference arbitration: find the top priority, then walk from rr+1.
  function automatic int ref_pick(input logic [3:0] v, input int rr);
    int best = -1;
    for (int i = 0; i < 4; i++)
      if (v[i] && int'(prio_a[i]) > best) best = int'(prio_a[i]);
    for (int k = 1; k <= 4; k++) begin
      int j = (rr + k) % 4;
      if (v[j] && int'(prio_a[j]) == best) return j;
    end
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (uart_rts !== 1'b0 || req_next !== 4'b0 || proto_err !== 1'b0 || uart_d_in !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d rts=%b next=%b err=%b din=%h required 0/0000/0/0", c, uart_rts, req_next, proto_err, uart_d_in);
      end
      tick();
    end
    n_cmp++;
    if (grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_grant_id got=%0d required 0", grant_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_prio(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) data_a[i] = 8'(8'h10 + i);
    data_a[2] = 8'h41;
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b0) begin n_bad++; $display("FAIL single_rts_t got=%b required 0", uart_rts); end
    tick();
    uart_next = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b1) begin n_bad++; $display("FAIL single_rts_t1 got=%b required 1", uart_rts); end
    n_cmp++;
    if (uart_d_in !== 32'h41) begin n_bad++; $display("FAIL single_din got=%h required 00000041", uart_d_in); end
    n_cmp++;
    if (grant_id !== 2'd2) begin n_bad++; $display("FAIL single_grant got=%0d required 2", grant_id); end
    n_cmp++;
    if (req_next !== 4'b0100) begin n_bad++; $display("FAIL single_req_next got=%b required 0100", req_next); end
    tick();
    uart_next = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b0 || req_next !== 4'b0 || uart_d_in !== 32'h0) begin
      n_bad++;
      $display("FAIL single_idle_after rts=%b next=%b din=%h required 0/0000/0", uart_rts, req_next, uart_d_in);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int id;
    do_reset();
    set_prio(1, 1, 1, 1);
    req_valid = 4'b1111;
    uart_next = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_grant(id);
      n_cmp++;
      if (id !== k % 4) begin n_bad++; $display("FAIL rr_grant k=%0d got=%0d required %0d", k, id, k % 4); end
    end
    uart_next = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_priority();
    int id;
    int exp_seq [6] = '{1, 2, 1, 2, 1, 0};
    do_reset();
    set_prio(3, 5, 5, 1);
    req_valid = 4'b1111;
    uart_next = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req_valid = 4'b1011;
      if (k == 5) req_valid = 4'b1001;
      next_grant(id);
      n_cmp++;
      if (id !== exp_seq[k]) begin n_bad++; $display("FAIL prio_grant k=%0d got=%0d required %0d", k, id, exp_seq[k]); end
    end
    uart_next = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_no_preempt();
    int id;
    do_reset();
    set_prio(1, 0, 0, 7);
    req_valid = 4'b0001;
    uart_next = 1'b0;
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b1 || grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL preempt_hold rts=%b grant=%0d required 1/0", uart_rts, grant_id);
    end
    tick();
    uart_next = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_next !== 4'b0001 || grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL preempt_pop next=%b grant=%0d required 0001/0", req_next, grant_id);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b0 || req_next !== 4'b0) begin
      n_bad++;
      $display("FAIL preempt_idle_gap rts=%b next=%b required 0/0000", uart_rts, req_next);
    end
    next_grant(id);
    n_cmp++;
    if (id !== 3) begin n_bad++; $display("FAIL preempt_next got=%0d required 3", id); end
    uart_next = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_proto_err();
    int id;
    do_reset();
    set_prio(0, 0, 0, 0);
    req_valid = 4'b0100;
    uart_next = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b1 || grant_id !== 2'd2) begin
      n_bad++;
      $display("FAIL perr_grant rts=%b grant=%0d required 1/2", uart_rts, grant_id);
    end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (req_next !== 4'b0 || proto_err !== 1'b0) begin
      n_bad++;
      $display("FAIL perr_drop_cycle next=%b err=%b required 0000/0", req_next, proto_err);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b0 || proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL perr_set rts=%b err=%b required 0/1", uart_rts, proto_err);
    end
    for (int c = 0; c < 5; c++) tick();
    req_valid = 4'b0010;
    uart_next = 1'b1;
    next_grant(id);
    n_cmp++;
    if (id !== 1 || proto_err !== 1'b1) begin
      n_bad++;
      $display("FAIL perr_sticky grant=%0d err=%b required 1/1", id, proto_err);
    end
    uart_next = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b1 || grant_id !== 2'd1) begin
      n_bad++;
      $display("FAIL rstmid_busy rts=%b grant=%0d required 1/1", uart_rts, grant_id);
    end
    reset     = 1'b1;
    uart_next = 1'b1;
    #1;
    n_cmp++;
    if (req_next !== 4'b0) begin n_bad++; $display("FAIL rstmid_no_pop got=%b required 0000", req_next); end
    tick();
    reset     = 1'b0;
    uart_next = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (uart_rts !== 1'b0 || proto_err !== 1'b0 || grant_id !== 2'd0 || req_next !== 4'b0) begin
      n_bad++;
      $display("FAIL rstmid_after rts=%b err=%b grant=%0d next=%b required 0/0/0/0000", uart_rts, proto_err, grant_id, req_next);
    end
    tick();
    req_valid = 4'b1111;
    uart_next = 1'b1;
    next_grant(id);
    n_cmp++;
    if (id !== 0) begin n_bad++; $display("FAIL rstmid_rr_ptr got=%0d required 0", id); end
    uart_next = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    bit          m_busy = 1'b0;
    bit          m_err  = 1'b0;
    int          m_grant = 0;
    int          m_rr = 3;
    logic [31:0] exp_din;
    logic [3:0]  exp_next;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) < 3);
      for (int i = 0; i < 4; i++) begin
        data_a[i] = 8'($urandom);
        prio_a[i] = 3'($urandom_range(0, 7));
      end
      req_valid = 4'($urandom) | 4'($urandom);
      uart_next = 1'($urandom);
      @(negedge clk);
      exp_din  = m_busy ? {24'h0, data_a[m_grant]} : 32'h0;
      exp_next = (m_busy && uart_next && !reset) ? 4'(1 << m_grant) : 4'b0;
      n_cmp++;
      if (uart_rts !== m_busy) begin n_bad++; $display("FAIL rnd_rts cyc=%0d got=%b required %b", c, uart_rts, m_busy); end
      n_cmp++;
      if (uart_d_in !== exp_din) begin n_bad++; $display("FAIL rnd_din cyc=%0d got=%h required %h", c, uart_d_in, exp_din); end
      n_cmp++;
      if (req_next !== exp_next) begin n_bad++; $display("FAIL rnd_req_next cyc=%0d got=%b required %b", c, req_next, exp_next); end
      n_cmp++;
      if (int'(grant_id) !== m_grant) begin n_bad++; $display("FAIL rnd_grant cyc=%0d got=%0d required %0d", c, grant_id, m_grant); end
      n_cmp++;
      if (proto_err !== m_err) begin n_bad++; $display("FAIL rnd_err cyc=%0d got=%b required %b", c, proto_err, m_err); end
      if (reset) begin
        m_busy = 1'b0; m_err = 1'b0; m_grant = 0; m_rr = 3;
      end else if (!m_busy) begin
        if (req_valid != 4'b0) begin
          m_grant = ref_pick(req_valid, m_rr);
          m_busy  = 1'b1;
        end
      end else if (uart_next) begin
        m_rr   = m_grant;
        m_busy = 1'b0;
      end else if (!req_valid[m_grant]) begin
        m_err  = 1'b1;
        m_busy = 1'b0;
      end
      tick();
    end
    reset     = 1'b0;
    req_valid = 4'b0000;
    uart_next = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    uart_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_a[i] = 8'h00;
      prio_a[i] = 3'd0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_no_preempt();
    test_proto_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout compared=%0d required completion", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
